// File: rtl/serial_flag_comparator.sv
// serial_flag_comparator
// Multi-cycle magnitude compare of two WIDTH-bit operands, DIGIT bits per
// cycle, MSB digit first, under a start/busy/done handshake. The result is
// captured into held flags: ZF (A == B), CF (A < B unsigned) and LF
// (A < B signed, two's complement).
//
// Build option: define COMPARATOR_EARLY_EXIT_EN to finish the compare on the
// first differing digit. Without it, every compare takes WIDTH/DIGIT cycles.
// The flag values are the same in both builds.
//
// state  | meaning
// S_IDLE | waiting for CMPsignal; flags held
// S_RUN  | walking digits from index NDIG-1 down to 0

module serial_flag_comparator #(
    parameter int WIDTH = 18,
    parameter int DIGIT = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] CMP1,
    input  logic [WIDTH-1:0] CMP2,
    input  logic             CMPsignal,
    output logic             busy,
    output logic             done,
    output logic             ZF,
    output logic             CF,
    output logic             LF
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_flag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_decided;
    logic             r_lt;

    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic             w_diff;
    logic             w_dec_nxt;
    logic             w_lt_nxt;
    logic             w_cf_nxt;
    logic             w_last;

    // Select the current digit of both latched operands.
    always_comb begin
        w_da = '0;
        w_db = '0;
        for (int d = 0; d < NDIG; d++) begin
            if (r_idx == IW'(d)) begin
                w_da = r_a[d*DIGIT +: DIGIT];
                w_db = r_b[d*DIGIT +: DIGIT];
            end
        end
    end

    // The first differing digit decides the ordering; later digits cannot override it.
    assign w_diff    = (w_da != w_db);
    assign w_dec_nxt = r_decided | w_diff;
    assign w_lt_nxt  = r_decided ? r_lt : (w_da < w_db);
    assign w_cf_nxt  = w_dec_nxt & w_lt_nxt;

`ifdef COMPARATOR_EARLY_EXIT_EN
    assign w_last = (r_idx == '0) || w_dec_nxt;
`else
    assign w_last = (r_idx == '0);
`endif

    // Handshake FSM, digit walk and flag update; flags move only at completion or clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ZF        <= 1'b0;
            CF        <= 1'b0;
            LF        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (CMPsignal) begin
                        r_a       <= CMP1;
                        r_b       <= CMP2;
                        r_idx     <= IW'(NDIG - 1);
                        r_decided <= 1'b0;
                        r_lt      <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_decided <= w_dec_nxt;
                    r_lt      <= w_lt_nxt;
                    r_idx     <= r_idx - IW'(1);
                    if (w_last) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ZF      <= ~w_dec_nxt;
                        CF      <= w_cf_nxt;
                        // Opposite signs: the negative operand is the smaller one.
                        LF      <= (r_a[WIDTH-1] != r_b[WIDTH-1]) ? r_a[WIDTH-1] : w_cf_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_flag_comparator.sv
// Testbench for serial_flag_comparator (WIDTH = 18, DIGIT = 3).
// Honours COMPARATOR_EARLY_EXIT_EN when defined for the whole build.

module tb_serial_flag_comparator;

    localparam int WIDTH = 18;
    localparam int DIGIT = 3;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic [WIDTH-1:0] CMP1 = '0;
    logic [WIDTH-1:0] CMP2 = '0;
    logic             CMPsignal = 1'b0;
    logic             busy;
    logic             done;
    logic             ZF;
    logic             CF;
    logic             LF;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference flag state, derived from plain integer comparisons.
    logic m_zf = 1'b0;
    logic m_cf = 1'b0;
    logic m_lf = 1'b0;

    serial_flag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .clear     (clear),
        .CMP1      (CMP1),
        .CMP2      (CMP2),
        .CMPsignal (CMPsignal),
        .busy      (busy),
        .done      (done),
        .ZF        (ZF),
        .CF        (CF),
        .LF        (LF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMPARATOR_EARLY_EXIT_EN
        int da;
        int db;
        for (int k = 1; k <= NDIG; k++) begin
            da = (int'(a) >> ((NDIG - k) * DIGIT)) % (1 << DIGIT);
            db = (int'(b) >> ((NDIG - k) * DIGIT)) % (1 << DIGIT);
            if (da != db) return k;
        end
        return NDIG;
`else
        if (a == b) return NDIG;
        return NDIG;
`endif
    endfunction

    task automatic model_update(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        m_zf = (a == b);
        m_cf = (a < b);
        m_lf = ($signed(a) < $signed(b));
    endtask

    task automatic check_flags(input string tag);
        check({tag, " flags"}, 32'({ZF, CF, LF}), 32'({m_zf, m_cf, m_lf}));
    endtask

    // Call between edges; returns #1 after the start edge with operands scrambled.
    task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        CMP1      = a;
        CMP2      = b;
        CMPsignal = 1'b1;
        @(posedge clk);
        #1;
        CMPsignal = 1'b0;
        CMP1      = WIDTH'($urandom);
        CMP2      = WIDTH'($urandom);
    endtask

    // Full compare: ends #1 after the completion edge (the done cycle).
    task automatic do_cmp(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int spur_at);
        int cyc;
        bit seen;
        int lat;
        cyc  = 0;
        seen = 0;
        lat  = exp_latency(a, b);
        start(a, b);
        while (!seen && cyc < 3 * NDIG + 4) begin
            if (spur_at != 0 && cyc == spur_at - 1) begin
                CMPsignal = 1'b1;
                CMP1      = WIDTH'($urandom);
                CMP2      = WIDTH'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (spur_at != 0 && cyc == spur_at) CMPsignal = 1'b0;
            if (done) begin
                seen = 1;
            end else begin
                check({tag, " busy"}, 32'(busy), 32'd1);
                check_flags({tag, " midrun"});
            end
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, cyc, lat);
        model_update(a, b);
        check_flags(tag);
        check({tag, " busy at done"}, 32'(busy), 32'd0);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk);
        #1;
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check_flags(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        #1;
        check("reset outputs", 32'({busy, done, ZF, CF, LF}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        #1;
        idle_cycle("post reset");

        do_cmp("equal", 18'h2A5A5, 18'h2A5A5, 0);
        idle_cycle("equal after");
        do_cmp("lsb diff", 18'h00001, 18'h00002, 0);
        do_cmp("sign diff", 18'h20000, 18'h00001, 0);
        idle_cycle("sign after");

        // Start while busy is ignored; restart in the done cycle is accepted.
        do_cmp("spur", 18'h0ABCD, 18'h0ABCD, 2);
        do_cmp("b2b", 18'h3FFFF, 18'h00000, 0);
        idle_cycle("b2b after 1");
        idle_cycle("b2b after 2");

        // Clear mid-compare.
        do_cmp("pre clear", 18'h2A5A5, 18'h2A5A5, 0);
        idle_cycle("pre clear after");
        start(18'h11111, 18'h11111);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        clear = 1'b1;
        #1;
        m_zf = 1'b0;
        m_cf = 1'b0;
        m_lf = 1'b0;
        check("clear outputs", 32'({busy, done, ZF, CF, LF}), 32'd0);
        #1;
        clear = 1'b0;
        repeat (NDIG + 3) idle_cycle("after clear");
        do_cmp("post clear", 18'h00010, 18'h20010, 0);

        // Flags hold while operands wiggle without a start.
        repeat (10) begin
            @(posedge clk);
            #1;
            CMP1 = WIDTH'($urandom);
            CMP2 = WIDTH'($urandom);
            check("hold done", 32'(done), 32'd0);
            check_flags("hold");
        end

        // Randomized compares, mixing equal, unrelated and near-equal operands.
        repeat (40) begin
            a = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = WIDTH'($urandom);
                2:       b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: b = a ^ WIDTH'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 1) == 1) idle_cycle("rnd gap");
            do_cmp("rnd", a, b, 0);
        end
        idle_cycle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_flag_comparator.md
# serial_flag_comparator

Parametrised, multi-cycle compare unit that replaces the fixed 18-bit single-cycle comparator in the CPU datapath. It compares two WIDTH-bit operands DIGIT bits per cycle, starting at the MSB, under a start/busy/done handshake. On completion it updates a registered flag set: zero, unsigned-less (carry) and signed-less. The flags are held for the branch unit until the next completed compare or a clear.

## Interface
Parameters:
- WIDTH, 18: operand width in bits. Must be ≥ 2.
- DIGIT, 3: bits compared per cycle. WIDTH % DIGIT ≠ 0 is an elaboration error.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- clear  in  1  reset; asynchronous and active-high.
- CMP1  in  WIDTH  operand A.
- CMP2  in  WIDTH  operand B.
- CMPsignal  in  1  start request. Sampled only in IDLE.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse; flags are valid and updated in this same cycle.
- ZF  out  1  registered flag: A == B.
- CF  out  1  registered flag: A < B, unsigned.
- LF  out  1  registered flag: A < B, two's-complement signed.

## Operation
- NDIG = WIDTH/DIGIT.
- States: IDLE and RUN.
- IDLE:
  - When CMPsignal = 1 at an edge, latch CMP1 and CMP2 into internal operand registers.
  - Load digit index = NDIG-1, clear the decided bit, and go to RUN.
  - Operand inputs are don't-care after the start edge.
- RUN, per cycle:
  - Compare digit [index*DIGIT +: DIGIT] of the latched A and B.
  - On the first differing digit, record lt = (A_digit < B_digit) unsigned and set decided. Later digits cannot change this result.
  - Decrement index.
- Completion: RUN ends after digit 0 is processed. The final edge writes:
  - ZF = ~decided
  - CF = decided & lt
  - LF = (A[WIDTH-1] ≠ B[WIDTH-1]) ? A[WIDTH-1] : CF
- After completion the block returns to IDLE, with done = 1 for exactly one cycle.
- Flags change only at a completion edge or on clear. They are never modified mid-compare.
- CMPsignal while busy = 1 is ignored; there is no queueing.
- CMPsignal during the done cycle: the block is already in IDLE, so a new compare starts (back-to-back operation).
- Clear, asserted at any time including mid-RUN:
  - Immediately forces IDLE with busy = 0, done = 0, ZF = CF = LF = 0, and clears index and decided.
  - The in-flight compare is lost. No done pulse is produced for it.
- Reset values: busy 0, done 0, ZF 0, CF 0, LF 0.

## Timing
- Start edge E0: CMPsignal is sampled and busy rises in the cycle after E0.
- Without early exit, latency is NDIG cycles:
  - The completion edge is E0+NDIG.
  - done = 1 and flags are new during cycle E0+NDIG to E0+NDIG+1.
  - busy = 0 in that same cycle.
- With early exit (see Configuration), the completion edge is E0+k, where k is the 1-based position from the MSB of the first differing digit. Equal operands always take NDIG cycles.
- Minimum start-to-start spacing: latency + 0 cycles (restart is allowed in the done cycle).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- COMPARATOR_EARLY_EXIT_EN:
  - Defined: RUN terminates at the edge on which decided first becomes set. Flags and done are produced at that edge.
  - Undefined: RUN always processes all NDIG digits, giving fixed latency.
- Flag values are identical in both builds; only latency differs.

## Test plan
All scenarios use WIDTH = 18, DIGIT = 3, so NDIG = 6.
- **Equal operands:** A = B = 18'h2A5A5 → done at E0+6 in both builds; ZF = 1, CF = 0, LF = 0.
- **Difference in LSB digit:** A = 18'h00001, B = 18'h00002 → done at E0+6 in both builds; ZF = 0, CF = 1, LF = 1.
- **Sign/MSB difference:** A = 18'h20000, B = 18'h00001 → ZF = 0, CF = 0, LF = 1. done at E0+1 with COMPARATOR_EARLY_EXIT_EN defined, E0+6 without.
- **Start while busy:** pulse CMPsignal at E0+2 with different operands → ignored; exactly one done; flags reflect the first operands. Then, in the done cycle, start A = 18'h3FFFF, B = 18'h00000 → second done follows with CF = 0, LF = 1.
- **Clear mid-compare:** prior flags ZF = 1. Start a compare, then assert clear for part of a cycle at E0+3 → busy, ZF, CF and LF all 0 immediately, with no done pulse. A subsequent start completes normally.
- **Flag hold:** after a completed compare, toggle CMP1 and CMP2 freely for 10 cycles without CMPsignal → ZF, CF and LF are unchanged and done stays 0.
